// File: rtl/vga_pipe_pkg.sv
// ---------------------------------------------------------------------------
// vga_pipe_pkg
// Shared constants and types for the VGA pixel pipeline.
//   - register addresses (REG_BG .. REG_CTRL, REG_RSVD)
//   - colour width (6) and coordinate width (10)
//   - default raw-to-visible offsets
//   - regs_t: one full copy of the programmable register set
//   - in_span: inclusive unsigned range test used for the rectangle
// ---------------------------------------------------------------------------
package vga_pipe_pkg;

    localparam int COLOR_W      = 6;
    localparam int COORD_W      = 10;
    localparam int ADDR_W       = 3;

    localparam int DEF_H_OFFSET = 144;
    localparam int DEF_V_OFFSET = 35;

    localparam logic [ADDR_W-1:0] REG_BG   = 3'd0;
    localparam logic [ADDR_W-1:0] REG_RECT = 3'd1;
    localparam logic [ADDR_W-1:0] REG_X0   = 3'd2;
    localparam logic [ADDR_W-1:0] REG_Y0   = 3'd3;
    localparam logic [ADDR_W-1:0] REG_X1   = 3'd4;
    localparam logic [ADDR_W-1:0] REG_Y1   = 3'd5;
    localparam logic [ADDR_W-1:0] REG_CTRL = 3'd6;
    localparam logic [ADDR_W-1:0] REG_RSVD = 3'd7;

    // ctrl[0] = rect enable, ctrl[1] = grid enable
    typedef struct packed {
        logic [COLOR_W-1:0] bg;
        logic [COLOR_W-1:0] rect;
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [1:0]         ctrl;
    } regs_t;

    // lo > hi can never be satisfied, so an inverted span never hits.
    function automatic logic in_span(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_pixel_pipe_reg_bank.sv
// ---------------------------------------------------------------------------
// vga_reg_bank
// Shadow/live register bank with frame-synchronous commit.
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   vs_i              raw vertical sync from the timing generator
//   wr_valid/wr_ready host write handshake
//   wr_addr, wr_data  register address and data
//   live              registers currently driving the picture
//   frame_start       one-cycle pulse during the commit cycle
//
// Handshake: a write transfers on the rising edge where wr_valid and
// wr_ready are both 1; wr_ready does not depend on wr_valid. wr_ready is
// low during reset and during the commit cycle, so a host write can never
// land on the same edge as the shadow-to-live copy.
//
// Commit timing: vs_i is registered twice (vs_r, vs_rr). A 1->0 step
// between them registers frame_start, and the live copy is loaded at the
// end of that frame_start cycle. A write accepted in the preceding cycle
// is therefore already in the shadow and is included.
// ---------------------------------------------------------------------------
module vga_reg_bank
    import vga_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               vs_i,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COORD_W-1:0] wr_data,
    output regs_t              live,
    output logic               frame_start
);

    regs_t shadow;
    logic  vs_r;
    logic  vs_rr;

    assign wr_ready = !rst && !frame_start;

    // Edge detect resets high so a vs_i held low out of reset is not
    // mistaken for a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_r        <= 1'b1;
            vs_rr       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vs_r        <= vs_i;
            vs_rr       <= vs_r;
            frame_start <= vs_rr && !vs_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (wr_valid && wr_ready) begin
            case (wr_addr)
                REG_BG:   shadow.bg   <= wr_data[COLOR_W-1:0];
                REG_RECT: shadow.rect <= wr_data[COLOR_W-1:0];
                REG_X0:   shadow.x0   <= wr_data;
                REG_Y0:   shadow.y0   <= wr_data;
                REG_X1:   shadow.x1   <= wr_data;
                REG_Y1:   shadow.y1   <= wr_data;
                REG_CTRL: shadow.ctrl <= wr_data[1:0];
                default:  ;  // reserved address: accepted, discarded
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live <= '0;
        end else if (frame_start) begin
            live <= shadow;
        end
    end

endmodule

// File: rtl/vga_pixel_pipe.sv
// ---------------------------------------------------------------------------
// vga_pixel_pipe
// Pixel generation stage after the VGA timing generator. Converts raw
// counter positions to visible coordinates and selects background, a
// single filled rectangle, or (optionally) a grid overlay.
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   hs_i, vs_i               sync inputs (polarity passed through)
//   x_i, y_i, active_i       raw counter position and visible flag
//   wr_valid/wr_ready        host register write handshake
//   wr_addr, wr_data         register address and data
//   hs_o, vs_o, rgb          outputs, 2 clocks after the inputs
//   frame_start              pulse on each register commit
// Parameters: H_OFFSET, V_OFFSET = raw x/y of first visible column/row.
// Build option: define VGA_PIPE_GRID_EN to build the grid overlay
// (CTRL bit1); otherwise bit1 is stored but has no effect.
// ---------------------------------------------------------------------------
module vga_pixel_pipe
    import vga_pipe_pkg::*;
#(
    parameter int H_OFFSET = DEF_H_OFFSET,
    parameter int V_OFFSET = DEF_V_OFFSET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hs_i,
    input  logic               vs_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic               active_i,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COORD_W-1:0] wr_data,
    output logic               hs_o,
    output logic               vs_o,
    output logic [COLOR_W-1:0] rgb,
    output logic               frame_start
);

    regs_t live;

    vga_reg_bank u_reg_bank (
        .clk         (clk),
        .rst         (rst),
        .vs_i        (vs_i),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .live        (live),
        .frame_start (frame_start)
    );

    // Stage 1: visible coordinates (modulo 2^10) and delayed controls
    logic [COORD_W-1:0] px_q;
    logic [COORD_W-1:0] py_q;
    logic               act_q;
    logic               hs_q;
    logic               vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            px_q  <= '0;
            py_q  <= '0;
            act_q <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            px_q  <= x_i - COORD_W'(H_OFFSET);
            py_q  <= y_i - COORD_W'(V_OFFSET);
            act_q <= active_i;
            hs_q  <= hs_i;
            vs_q  <= vs_i;
        end
    end

    // Colour decision on stage-1 values and live registers
    logic               hit;
    logic [COLOR_W-1:0] pix;

    always_comb begin
        hit = live.ctrl[0]
              && in_span(px_q, live.x0, live.x1)
              && in_span(py_q, live.y0, live.y1);
        pix = hit ? live.rect : live.bg;
`ifdef VGA_PIPE_GRID_EN
        // Grid lines every 32 pixels override both rect and background.
        if (live.ctrl[1] && ((px_q[4:0] == 5'd0) || (py_q[4:0] == 5'd0))) begin
            pix = ~live.rect;
        end
`endif
        if (!act_q) begin
            pix = '0;
        end
    end

`ifndef VGA_PIPE_GRID_EN
    // Grid enable is kept in the register for software visibility only.
    logic unused_ctrl;
    assign unused_ctrl = live.ctrl[1];
`endif

    // Stage 2: registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb  <= '0;
            hs_o <= 1'b0;
            vs_o <= 1'b0;
        end else begin
            rgb  <= pix;
            hs_o <= hs_q;
            vs_o <= vs_q;
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
module tb_vga_pixel_pipe;
  import vga_pipe_pkg::*;

  localparam int H_OFF = 144;
  localparam int V_OFF = 35;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs_i = 1'b1, vs_i = 1'b1, active_i = 1'b0;
  logic [9:0] x_i = '0, y_i = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = '0;
  logic [9:0] wr_data = '0;
  logic       hs_o, vs_o, frame_start;
  logic [5:0] rgb;

  always #5 clk = ~clk;

  vga_pixel_pipe #(.H_OFFSET(H_OFF), .V_OFFSET(V_OFF)) dut (
    .clk(clk), .rst(rst), .hs_i(hs_i), .vs_i(vs_i), .x_i(x_i), .y_i(y_i),
    .active_i(active_i), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .hs_o(hs_o), .vs_o(vs_o),
    .rgb(rgb), .frame_start(frame_start)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  // {check_enable, hs, vs, rgb}
  logic [8:0] exp_q[$];
  logic       chk_en = 1'b0;
  logic       use_tab = 1'b0;
  logic [5:0] tab_rgb = '0;

  // reference register model: shadow and live copies
  logic [9:0] sh[8];
  logic [9:0] lv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_rgb(input logic [9:0] x, input logic [9:0] y, input logic act);
    logic [9:0] px, py;
    logic       hit;
    logic [5:0] c;
    px  = x - 10'(H_OFF);
    py  = y - 10'(V_OFF);
    hit = lv[6][0] && (px >= lv[2]) && (px <= lv[4]) && (py >= lv[3]) && (py <= lv[5]);
    c   = hit ? lv[1][5:0] : lv[0][5:0];
`ifdef VGA_PIPE_GRID_EN
    if (lv[6][1] && (px[4:0] == 5'd0 || py[4:0] == 5'd0)) c = ~lv[1][5:0];
`endif
    if (!act) c = 6'h00;
    return c;
  endfunction

  // One clock: record what the current inputs should produce, advance,
  // then compare the entry whose 2-cycle latency has elapsed.
  task automatic step();
    logic [8:0] e;
    logic [5:0] c;
    c = use_tab ? tab_rgb : model_rgb(x_i, y_i, active_i);
    exp_q.push_back({chk_en, hs_i, vs_i, c});
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      if (e[8]) check("pixel_out", {24'd0, hs_o, vs_o, rgb}, {24'd0, e[7:0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pix_exp(input int x, input int y, input logic act, input logic hs, input logic [5:0] c);
    x_i = 10'(x); y_i = 10'(y); active_i = act; hs_i = hs;
    use_tab = 1'b1; tab_rgb = c;
    step();
    use_tab = 1'b0;
  endtask

  function automatic logic [9:0] mask_data(input logic [2:0] a, input logic [9:0] d);
    case (a)
      3'd0, 3'd1: return {4'd0, d[5:0]};
      3'd6:       return {8'd0, d[1:0]};
      default:    return d;
    endcase
  endfunction

  task automatic write_reg(input logic [2:0] a, input logic [9:0] d);
    bit done;
    done = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 8 && !done; i++) begin
      if (wr_ready) done = 1;
      step();
    end
    wr_valid = 1'b0;
    if (done) begin
      if (a != 3'd7) sh[a] = mask_data(a, d);
    end else begin
      checks++; errors++;
      $display("FAIL wr_timeout: got no accept, expected accept for addr %0d", a);
    end
  endtask

  // Drive a vs falling edge; optionally hold a write across the commit cycle.
  task automatic commit(input bit collide, input logic [2:0] a, input logic [9:0] d);
    active_i = 1'b0;
    vs_i = 1'b0;
    step();
    check("fs_before", {31'd0, frame_start}, 32'd0);
    check("rdy_before", {31'd0, wr_ready}, 32'd1);
    step();
    check("fs_commit", {31'd0, frame_start}, 32'd1);
    check("rdy_commit", {31'd0, wr_ready}, 32'd0);
    if (collide) begin
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
    end
    step();
    for (int i = 0; i < 8; i++) lv[i] = sh[i];
    check("fs_after", {31'd0, frame_start}, 32'd0);
    check("rdy_after", {31'd0, wr_ready}, 32'd1);
    if (collide) begin
      step();
      wr_valid = 1'b0;
      sh[a] = mask_data(a, d);
    end
    repeat (2) step();
    vs_i = 1'b1;
    repeat (3) step();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         x;
    int         y;
    logic       act;
    logic       hs;
    logic [5:0] c;
  } vec_t;
  vec_t tab[10];

  initial begin
    for (int i = 0; i < 8; i++) begin sh[i] = '0; lv[i] = '0; end

    // rect X0=10..X1=12, Y=20 -> raw x 154..156, raw y 55; BG 03, RECT 30
    tab[0] = '{153, 55, 1'b1, 1'b1, 6'h03};
    tab[1] = '{154, 55, 1'b1, 1'b0, 6'h30};
    tab[2] = '{155, 55, 1'b1, 1'b1, 6'h30};
    tab[3] = '{156, 55, 1'b1, 1'b0, 6'h30};
    tab[4] = '{157, 55, 1'b1, 1'b1, 6'h03};
    tab[5] = '{155, 54, 1'b1, 1'b0, 6'h03};
    tab[6] = '{155, 56, 1'b1, 1'b1, 6'h03};
    tab[7] = '{155, 55, 1'b0, 1'b0, 6'h00};
    tab[8] = '{154, 55, 1'b0, 1'b1, 6'h00};
    tab[9] = '{144, 35, 1'b1, 1'b0, 6'h03};

    // ---- reset ----
    rst = 1'b1;
    repeat (3) step();
    check("rst_rgb", {26'd0, rgb}, 32'd0);
    check("rst_hs_o", {31'd0, hs_o}, 32'd0);
    check("rst_vs_o", {31'd0, vs_o}, 32'd0);
    check("rst_fs", {31'd0, frame_start}, 32'd0);
    check("rst_rdy", {31'd0, wr_ready}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    check("rdy_post_rst", {31'd0, wr_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      x_i = 10'(150 + i); y_i = 10'd55; active_i = 1'b1;
      step();
      check("idle_fs", {31'd0, frame_start}, 32'd0);
    end

    // ---- rect draw ----
    write_reg(REG_BG, 10'h003);
    write_reg(REG_RECT, 10'h030);
    write_reg(REG_X0, 10'd10);
    write_reg(REG_Y0, 10'd20);
    write_reg(REG_X1, 10'd12);
    write_reg(REG_Y1, 10'd20);
    write_reg(REG_CTRL, 10'h3FD);   // high bits dropped -> CTRL = 1
    write_reg(REG_RSVD, 10'h3FF);
    pix_exp(155, 55, 1'b1, 1'b1, 6'h00);  // not yet committed: BG still black
    commit(0, 3'd0, 10'd0);
    for (int i = 0; i < 10; i++) pix_exp(tab[i].x, tab[i].y, tab[i].act, tab[i].hs, tab[i].c);
    hs_i = 1'b1;

    // random pixels against the model
    for (int i = 0; i < 30; i++) begin
      x_i = 10'($urandom_range(140, 200));
      y_i = 10'($urandom_range(50, 60));
      active_i = 1'($urandom_range(0, 1));
      hs_i = 1'($urandom_range(0, 1));
      step();
    end
    hs_i = 1'b1;

    // ---- tear-free update ----
    write_reg(REG_X0, 10'd0);
    pix_exp(145, 55, 1'b1, 1'b1, 6'h03);
    pix_exp(154, 55, 1'b1, 1'b1, 6'h30);
    commit(0, 3'd0, 10'd0);
    pix_exp(145, 55, 1'b1, 1'b1, 6'h30);
    pix_exp(144, 55, 1'b1, 1'b1, 6'h30);

    // ---- commit collision: X1=30 held across the commit ----
    commit(1, REG_X1, 10'd30);
    pix_exp(164, 55, 1'b1, 1'b1, 6'h03);
    commit(0, 3'd0, 10'd0);
    pix_exp(164, 55, 1'b1, 1'b1, 6'h30);
    pix_exp(174, 55, 1'b1, 1'b0, 6'h30);
    pix_exp(175, 55, 1'b1, 1'b1, 6'h03);

    // ---- inverted rect ----
    write_reg(REG_X0, 10'd20);
    write_reg(REG_X1, 10'd10);
    commit(0, 3'd0, 10'd0);
    for (int i = 0; i < 32; i++) pix_exp(144 + i, 55, 1'b1, 1'b1, 6'h03);

    // ---- grid (CTRL bit1) ----
    write_reg(REG_X0, 10'd0);
    write_reg(REG_X1, 10'd40);
    write_reg(REG_Y0, 10'd0);
    write_reg(REG_Y1, 10'd40);
    write_reg(REG_CTRL, 10'd3);
    commit(0, 3'd0, 10'd0);
`ifdef VGA_PIPE_GRID_EN
    pix_exp(176, 55, 1'b1, 1'b1, 6'h0F);
    pix_exp(177, 35, 1'b1, 1'b1, 6'h0F);
`else
    pix_exp(176, 55, 1'b1, 1'b1, 6'h30);
    pix_exp(177, 35, 1'b1, 1'b1, 6'h30);
`endif
    pix_exp(177, 56, 1'b1, 1'b1, 6'h30);
    pix_exp(176, 55, 1'b0, 1'b0, 6'h00);

    // drain pipeline
    active_i = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $finish;
  end

endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Pixel-generation stage directly downstream of the VGA timing generator. Consumes raw `hs`/`vs`/`x`/`y`/`active`, converts raw counter positions to visible-pixel coordinates, and produces a 6-bit RGB pixel (2 bits per channel). The pixel is either a background colour or one filled rectangle. The block also provides a small register bank, written by the host-command path, that commits atomically at frame start so the picture never tears.

## Interface
- `H_OFFSET`, default 144: raw `x` value of the first visible column (sync plus back porch).
- `V_OFFSET`, default 35: raw `y` value of the first visible row.
- `clk` in 1: pixel clock, same clock as the timing generator.
- `rst` in 1: synchronous, active-high reset.
- `hs_i`, `vs_i` in 1 each: sync inputs from the timing generator. Polarity is passed through unchanged.
- `x_i`, `y_i` in 10 each: raw counter positions.
- `active_i` in 1: visible-region flag.
- `wr_valid` in 1: host register-write request.
- `wr_ready` out 1: block can accept a write.
- `wr_addr` in 3: register address.
- `wr_data` in 10: register data.
- `hs_o`, `vs_o` out 1 each: sync outputs, delayed to align with `rgb`.
- `rgb` out 6: {R[1:0], G[1:0], B[1:0]}.
- `frame_start` out 1: single-cycle pulse on each register commit.

## Operation
- **Register map:** each register has a shadow copy and a live copy.
  - 0: BG colour [5:0]
  - 1: RECT colour [5:0]
  - 2: X0
  - 3: Y0
  - 4: X1
  - 5: Y1
  - 6: CTRL. Bit0 = rect enable; bit1 = grid enable (see Configuration).
  - 7: reserved. A write is accepted and discarded.
- **Write handshake:** a write transfers on a cycle where `wr_valid && wr_ready`. The shadow register is updated on that edge. Unused high data bits are dropped.
- **Commit:** a commit happens when a falling edge is detected on registered `vs_i` (previous 1, current 0).
  - On that edge, all live registers load from their shadows.
  - `frame_start` = 1 for that cycle.
  - `wr_ready` = 0 for that cycle, so a write can never race a commit.
- **Coordinates:** `px = x_i - H_OFFSET`, `py = y_i - V_OFFSET`, 10-bit modulo arithmetic. Values are only meaningful while `active_i` = 1.
- **Rect hit:** `X0 <= px <= X1` and `Y0 <= py <= Y1`, inclusive, unsigned, with CTRL bit0 = 1.
  - If `X0 > X1` or `Y0 > Y1`, there is never a hit; no wrap-around.
- **Pixel selection:**
  - `active` = 0: rgb = 0.
  - Hit: RECT colour.
  - Otherwise: BG colour.
- Only live registers affect the picture. Shadow writes made mid-frame are invisible until the next commit.

## Timing
- Pipeline latency is exactly 2 clocks from inputs to `rgb`/`hs_o`/`vs_o`.
  - Stage 1 registers px, py, active, hs, vs.
  - Stage 2 registers the colour decision and the syncs.
- `frame_start` is asserted 2 cycles after the `vs_i` falling edge appears on the input. This is 1 cycle for the edge-detect register plus the commit cycle.
- Values after `rst` deasserts:
  - `rgb`, `hs_o`, `vs_o`, `frame_start` = 0; all pipeline registers = 0.
  - All shadow and live registers = 0: BG black, rect disabled.
  - The vs edge-detect register = 1, so a held-low `vs_i` does not produce a spurious commit.
  - `wr_ready` = 0 while `rst` = 1, and 1 from the first cycle after reset.
- Reset asserted mid-frame or mid-write: all state clears on the next edge, and any in-flight write is lost.
- A write to register R in the same cycle a commit is pending is impossible, because `wr_ready` = 0 in that cycle. A write in the cycle before a commit is included in that commit.

## Configuration
- `VGA_PIPE_GRID_EN` defined:
  - With CTRL bit1 = 1, visible pixels where `px[4:0] == 0` or `py[4:0] == 0` show `~RECT colour`.
  - Grid has priority over the rect and over BG.
- Not defined:
  - CTRL bit1 is stored but ignored, and no grid logic is built.
  - Latency is unchanged in both builds.

## Structure
- Package `vga_pipe_pkg` holds:
  - register address constants (`REG_BG` … `REG_CTRL`);
  - the colour width (6) and coordinate width (10);
  - default H/V offsets.
- Sub-module `vga_reg_bank` contains the shadow/live registers, the write handshake, vs edge detection, and the `frame_start` generation.
- The top level contains the coordinate pipeline and the colour mux.

## Test plan
- **Reset:** reset then idle → `rgb` = 0, `frame_start` never pulses with `vs_i` held 1, `wr_ready` = 1 after reset.
- **Rect draw:** write BG = 6'h03, RECT = 6'h30, X0 = 10, Y0 = 20, X1 = 12, Y1 = 20, CTRL = 1, then one vs falling edge.
  - Next frame: raw (154..156, 55) → `rgb` 6'h30 two cycles later.
  - Raw (153, 55) and (157, 55) → 6'h03.
- **Tear-free update:** write X0 = 0 mid-frame → the current frame is unchanged, and the new value takes effect after the next `frame_start`.
- **Commit collision:** hold `wr_valid` across a vs falling edge.
  - `wr_ready` is 0 for exactly the commit cycle.
  - The write completes the next cycle and lands in the shadow only.
- **Inverted rect:** X0 = 20, X1 = 10 → no rect pixels anywhere.
- **Blanking:** `active_i` = 0 at any position inside the rect → `rgb` = 0. `hs_o`/`vs_o` equal `hs_i`/`vs_i` delayed by 2.
- **Grid (`VGA_PIPE_GRID_EN` builds):** CTRL = 2'b11, RECT = 6'h30 → visible pixel px = 32 shows 6'h0F.
